// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared constants, level type and gamma helper for the LED fader
package led_pwm_pkg;

  localparam int LVL_W    = 8;
  localparam int LVL_MAX  = 255;
  localparam int NUM_LEDS = 4;

  typedef logic [LVL_W-1:0] level_t;

  // Rounded square law: 0->0, 128->64, 255->255.
  function automatic level_t gamma_map(input level_t lvl);
    logic [15:0] sq;
    sq = 16'(lvl) * 16'(lvl) + 16'd255;
    return sq[15:8];
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one fading PWM channel: level register, step, duty map, compare
// Optional gamma duty map enabled by LED_PWM_GAMMA_EN.
module led_pwm_channel
  import led_pwm_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   tick_i,
  input  logic   target_on_i,
  input  level_t pwm_cnt_i,
  output logic   off_target_o,
  output logic   led_o
);

  level_t level_q, level_d;
  level_t duty;
  logic   led_q, led_d;

  always_comb begin
    level_d = level_q;
    if (tick_i) begin
      if (target_on_i && (level_q != level_t'(LVL_MAX))) begin
        level_d = level_q + 1'b1;
      end else if (!target_on_i && (level_q != '0)) begin
        level_d = level_q - 1'b1;
      end
    end
  end

`ifdef LED_PWM_GAMMA_EN
  assign duty = gamma_map(level_q);
`else
  assign duty = level_q;
`endif

  // Full scale is forced on; a plain compare would leave one dark cycle per period.
  assign led_d        = (duty == level_t'(LVL_MAX)) || (pwm_cnt_i < duty);
  assign off_target_o = target_on_i ? (level_q != level_t'(LVL_MAX)) : (level_q != '0);
  assign led_o        = led_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - four-channel LED fader with shared prescaler and PWM counter
// Gamma-corrected duty is selected with LED_PWM_GAMMA_EN.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int FADE_DIV = 4096,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] pat,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy
);

  localparam int                PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

  logic [NUM_LEDS-1:0] pat_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic [NUM_LEDS-1:0] off_target;

  assign tick      = (pre_q == PRE_LAST);
  assign pre_d     = tick ? '0 : pre_q + 1'b1;
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;
  assign busy_d    = |off_target;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      pat_q     <= pat;
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Channels step on pat_q, so a pat edge coinciding with a tick still moves toward the old target.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_pwm_channel u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick),
      .target_on_i  (pat_q[i]),
      .pwm_cnt_i    (pwm_cnt_q),
      .off_target_o (off_target[i]),
      .led_o        (led[i])
    );
  end

endmodule
